// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: assembles framed WIDTH-bit words from a
// qualified serial bit stream, with explicit frame_start framing and abort.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d_in,
    input  logic                       d_valid,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   bit_count,
    output logic                       abort
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dv_q, dv_d;
    logic             abort_q, abort_d;

    // first_word seeds a new word with bit 0; next_word appends one more bit.
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] next_word;

    always_comb begin
        if (MSB_FIRST) begin
            first_word = {{(WIDTH-1){1'b0}}, d_in};
            next_word  = {shreg_q[WIDTH-2:0], d_in};
        end else begin
            first_word = {d_in, {(WIDTH-1){1'b0}}};
            next_word  = {d_in, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        dv_d    = 1'b0;
        abort_d = 1'b0;
        if (d_valid) begin
            if (frame_start) begin
                // frame_start always restarts, even over a word about to complete.
                abort_d = (state_q == SHIFT);
                shreg_d = first_word;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d = next_word;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    dout_d  = next_word;
                    dv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            abort_q <= abort_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = (state_q == SHIFT);
    assign bit_count  = cnt_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one
// input stream; completed words are checked against a queue of expected words.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_in;
    logic       d_valid;
    logic       frame_start;

    logic [7:0] dout_m, dout_l;
    logic       dv_m, dv_l, busy_m, busy_l, ab_m, ab_l;
    logic [2:0] cnt_m, cnt_l;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_msb_q[$];
    logic [7:0] exp_lsb_q[$];
    logic       model_busy = 1'b0;
    logic [7:0] last_msb = 8'h00;
    logic [7:0] last_lsb = 8'h00;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid),
        .frame_start(frame_start), .dout(dout_m), .dout_valid(dv_m),
        .busy(busy_m), .bit_count(cnt_m), .abort(ab_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid),
        .frame_start(frame_start), .dout(dout_l), .dout_valid(dv_l),
        .busy(busy_l), .bit_count(cnt_l), .abort(ab_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Scoreboard: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (dv_m === 1'b1) begin
            checks++;
            if (exp_msb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_msb: unexpected strobe dout=%h", dout_m);
            end else begin
                logic [7:0] e;
                e = exp_msb_q.pop_front();
                if (dout_m !== e) begin
                    errors++;
                    $display("FAIL sb_msb: dout=%h expected %h", dout_m, e);
                end
            end
        end
        if (dv_l === 1'b1) begin
            checks++;
            if (exp_lsb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_lsb: unexpected strobe dout=%h", dout_l);
            end else begin
                logic [7:0] e;
                e = exp_lsb_q.pop_front();
                if (dout_l !== e) begin
                    errors++;
                    $display("FAIL sb_lsb: dout=%h expected %h", dout_l, e);
                end
            end
        end
        if ((dv_m & ab_m) === 1'b1 || (dv_l & ab_l) === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: dout_valid and abort both high");
        end
    end

    // One bit per cycle; on return the outputs reflect the edge that sampled it.
    task automatic drive_bit(input logic v, input logic fs, input logic d);
        @(negedge clk);
        d_valid     = v;
        frame_start = fs;
        d_in        = d;
        @(posedge clk);
        #1;
    endtask

    // Bit k of the word on the wire is m[7-k].
    task automatic send_word(input logic [7:0] m, input int gap_a, input int gap_b, input int ngap);
        logic exp_ab;
        exp_ab = model_busy;
        exp_msb_q.push_back(m);
        exp_lsb_q.push_back(rev8(m));
        for (int k = 0; k < 8; k++) begin
            drive_bit(1'b1, k == 0, m[7-k]);
            if (k == 0) begin
                checks++;
                if ({ab_m, ab_l, dout_m, dout_l} !== {exp_ab, exp_ab, last_msb, last_lsb}) begin
                    errors++;
                    $display("FAIL start_abort: abort=%b%b dout=%h/%h expected abort=%b dout=%h/%h",
                             ab_m, ab_l, dout_m, dout_l, exp_ab, last_msb, last_lsb);
                end
            end else begin
                checks++;
                if ({ab_m, ab_l} !== 2'b00) begin
                    errors++;
                    $display("FAIL abort_idle: abort=%b%b expected 00 at bit %0d", ab_m, ab_l, k);
                end
            end
            if (k < 7) begin
                checks++;
                if ({busy_m, cnt_m, busy_l, cnt_l, dv_m, dv_l} !== {1'b1, 3'(k + 1), 1'b1, 3'(k + 1), 2'b00}) begin
                    errors++;
                    $display("FAIL mid_word: busy=%b/%b cnt=%0d/%0d dv=%b%b expected busy=1 cnt=%0d dv=00",
                             busy_m, busy_l, cnt_m, cnt_l, dv_m, dv_l, k + 1);
                end
                if (k == gap_a || k == gap_b) begin
                    for (int g = 0; g < ngap; g++) begin
                        drive_bit(1'b0, 1'bx, 1'bx);
                        checks++;
                        if ({busy_m, cnt_m, busy_l, cnt_l, dv_m, dv_l, ab_m, ab_l} !==
                            {1'b1, 3'(k + 1), 1'b1, 3'(k + 1), 4'b0000}) begin
                            errors++;
                            $display("FAIL gap_hold: busy=%b cnt=%0d/%0d dv=%b%b ab=%b%b expected cnt=%0d, no strobes",
                                     busy_m, cnt_m, cnt_l, dv_m, dv_l, ab_m, ab_l, k + 1);
                        end
                    end
                end
            end else begin
                checks++;
                if ({dv_m, dv_l, busy_m, busy_l, cnt_m, cnt_l, dout_m, dout_l} !==
                    {4'b1100, 3'd0, 3'd0, m, rev8(m)}) begin
                    errors++;
                    $display("FAIL complete: dv=%b%b busy=%b%b cnt=%0d dout=%h/%h expected dv=11 busy=00 cnt=0 dout=%h/%h",
                             dv_m, dv_l, busy_m, busy_l, cnt_m, dout_m, dout_l, m, rev8(m));
                end
            end
        end
        model_busy = 1'b0;
        last_msb   = m;
        last_lsb   = rev8(m);
    endtask

    // Leaves a word of n bits (n >= 1) partially received.
    task automatic send_partial(input logic [7:0] m, input int n);
        for (int k = 0; k < n; k++) drive_bit(1'b1, k == 0, m[7-k]);
        model_busy = 1'b1;
        checks++;
        if ({busy_m, cnt_m, busy_l, cnt_l} !== {1'b1, 3'(n), 1'b1, 3'(n)}) begin
            errors++;
            $display("FAIL partial: busy=%b cnt=%0d/%0d expected busy=1 cnt=%0d", busy_m, cnt_m, cnt_l, n);
        end
    endtask

    task automatic idle_cycle();
        drive_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if ({dv_m, dv_l, ab_m, ab_l, busy_m, busy_l} !== 6'b0 || dout_m !== last_msb || dout_l !== last_lsb) begin
            errors++;
            $display("FAIL idle_hold: dv=%b%b ab=%b%b busy=%b%b dout=%h/%h expected zeros dout=%h/%h",
                     dv_m, dv_l, ab_m, ab_l, busy_m, busy_l, dout_m, dout_l, last_msb, last_lsb);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; d_valid = 1'b0; frame_start = 1'b0; d_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout_m, dout_l, dv_m, dv_l, busy_m, busy_l, cnt_m, cnt_l, ab_m, ab_l} !== '0) begin
            errors++;
            $display("FAIL reset: dout=%h/%h dv=%b%b busy=%b%b cnt=%0d/%0d ab=%b%b expected all zero",
                     dout_m, dout_l, dv_m, dv_l, busy_m, busy_l, cnt_m, cnt_l, ab_m, ab_l);
        end
        @(negedge clk);
        reset = 1'b0;
        last_msb = 8'h00; last_lsb = 8'h00; model_busy = 1'b0;
    endtask

    task automatic test_basic();
        send_word(8'hA5, -1, -1, 0);
        idle_cycle();
        send_word(8'hC0, -1, -1, 0);
        idle_cycle();
    endtask

    task automatic test_gaps();
        send_word(8'hA5, 2, 5, 3);
        idle_cycle();
        send_word(8'h00 | 8'($urandom_range(0, 255)), 0, 6, int'($urandom_range(1, 4)));
        idle_cycle();
    endtask

    task automatic test_abort();
        send_partial(8'hA0, 4);
        send_word(8'hFF, -1, -1, 0);
        idle_cycle();
        // Restart on what would have been the final bit: restart wins.
        send_partial(8'h81, 7);
        send_word(8'h5A, -1, -1, 0);
        idle_cycle();
    endtask

    task automatic test_reset_mid_word();
        send_partial(8'hE7, 5);
        @(negedge clk);
        reset = 1'b1; d_valid = 1'b1; frame_start = 1'b0; d_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy_m, busy_l, cnt_m, cnt_l, dout_m, dout_l, dv_m, dv_l, ab_m, ab_l} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b%b cnt=%0d/%0d dout=%h/%h dv=%b%b ab=%b%b expected all zero",
                     busy_m, busy_l, cnt_m, cnt_l, dout_m, dout_l, dv_m, dv_l, ab_m, ab_l);
        end
        @(negedge clk);
        reset = 1'b0; d_valid = 1'b0;
        last_msb = 8'h00; last_lsb = 8'h00; model_busy = 1'b0;
        send_word(8'h3C, -1, -1, 0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_word(8'h12, -1, -1, 0);
        send_word(8'h34, -1, -1, 0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            send_word(w, -1, -1, 0);
        end
        idle_cycle();
    endtask

    task automatic test_idle_drop();
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b1, 1'b0, i[0]);
            checks++;
            if ({busy_m, busy_l, cnt_m, cnt_l, dv_m, dv_l, ab_m, ab_l} !== '0) begin
                errors++;
                $display("FAIL idle_drop: busy=%b%b cnt=%0d/%0d dv=%b%b ab=%b%b expected all zero",
                         busy_m, busy_l, cnt_m, cnt_l, dv_m, dv_l, ab_m, ab_l);
            end
        end
        send_word(8'h96, -1, -1, 0);
        idle_cycle();
    endtask

    initial begin
        reset = 1'b0; d_valid = 1'b0; frame_start = 1'b0; d_in = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_reset_mid_word();
        test_back_to_back();
        test_idle_drop();
        repeat (2) idle_cycle();
        checks++;
        if (exp_msb_q.size() != 0 || exp_lsb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d/%0d words never produced, expected 0",
                     exp_msb_q.size(), exp_lsb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel stage directly downstream of the single-bit D flip-flop register. It consumes the registered serial bit stream and assembles framed WIDTH-bit words. Each completed word is presented on a parallel output with a one-cycle valid strobe. Framing is explicit: a frame_start qualifier marks the first bit of each word, and a frame_start arriving mid-word aborts the partial word.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
d_in  input  1  serial data bit (Q of the upstream flip-flop).
d_valid  input  1  d_in is a real bit this cycle.
frame_start  input  1  qualifies the current valid bit as bit 0 of a new word; ignored when d_valid=0.
dout  output  WIDTH  last completed word; holds until the next word completes.
dout_valid  output  1  one-cycle strobe: dout was updated on this edge.
busy  output  1  a word is partially received (state SHIFT).
bit_count  output  $clog2(WIDTH)  number of bits accepted in the current word; 0 in IDLE.
abort  output  1  one-cycle strobe: a partial word was discarded by frame_start.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset): when reset=1 at the rising edge, all of the following are cleared: state=IDLE, shift register=0, bit_count=0, dout=0, dout_valid=0, busy=0, abort=0. Reset has priority over all other inputs.
- Reset mid-word discards the partial word and raises no abort or dout_valid strobe.
- All outputs are registered; there are no combinational paths from input to output.
- A bit is accepted on a rising edge with d_valid=1 under the state rules below. Cycles with d_valid=0 are gaps: no state changes, and gaps of any length are allowed.
- FSM states: IDLE and SHIFT.
- IDLE:
  - d_valid=1 and frame_start=1: accept bit 0, set bit_count=1, go to SHIFT.
  - d_valid=1 and frame_start=0: drop the bit (no framing), stay in IDLE.
- SHIFT, d_valid=1 and frame_start=0:
  - Accept the bit and increment bit_count.
  - If this is bit WIDTH-1: load dout with the assembled word on the same edge, pulse dout_valid for 1 cycle, set bit_count=0, go to IDLE.
- SHIFT, d_valid=1 and frame_start=1 (abort):
  - Discard the partial word and pulse abort for 1 cycle.
  - Accept the current bit as bit 0 of a new word, set bit_count=1, stay in SHIFT. dout is unchanged.
  - This applies even when the aborted word was at bit WIDTH-1: frame_start wins over completion.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at the LSB end; word bit k goes to dout[WIDTH-1-k].
  - MSB_FIRST=0: shift right, new bit enters at the MSB end; word bit k goes to dout[k].
- Latency: dout and dout_valid update on the same edge that samples the last bit. There is no extra pipeline stage.
- Back-to-back words: the cycle immediately after a completion may carry frame_start+d_valid. That bit is accepted with no dead cycle, so the sustained rate is WIDTH bits per WIDTH cycles.
- busy=1 exactly while in SHIFT. dout_valid and abort are never high in the same cycle.
- When d_valid=0, X on d_in or frame_start must not affect state.

Test Plan:
- WIDTH=8, MSB_FIRST=1. Apply reset for 2 cycles, then frame_start+d_valid with bits 1,0,1,0,0,1,0,1 on consecutive cycles. Expect dout=8'hA5 and dout_valid=1 for exactly 1 cycle, on the edge sampling bit 7. busy=1 for 7 cycles, then returns to 0.
- Same word with 3 d_valid=0 gap cycles inserted after bits 2 and 5. Expect dout=8'hA5 with a single strobe. bit_count holds its value during the gaps.
- MSB_FIRST=0 instance, bits 1,0,1,0,0,1,0,1. Expect dout=8'hA5 reversed = 8'hA5. Then bits 1,1,0,0,0,0,0,0: expect dout=8'h03. The MSB_FIRST=1 instance gives 8'hC0 for the same bits.
- Abort: send 4 bits of a word, then frame_start with bits 1,1,1,1,1,1,1,1. Expect abort=1 for 1 cycle at the restart and no dout_valid for the partial word. Then dout=8'hFF with a single strobe.
- Reset mid-word: after 5 bits, assert reset for 1 cycle. Expect busy=0, bit_count=0, dout=0, and no strobes. A subsequent full word 8'h3C must complete correctly.
- Back-to-back: words 8'h12 and 8'h34 over 16 consecutive valid cycles, with frame_start on cycles 0 and 8. Expect strobes on cycles 7 and 15 with the correct values. Also check that valid bits without frame_start in IDLE are dropped, with no busy and no strobe.
